// File: rtl/approx_add_pkg.sv
// Shared limits and arithmetic helpers for the pipelined approximate adder.
// Helpers work on W_MAX-wide zero-extended operands; callers slice the result.
package approx_add_pkg;

    localparam int W_MAX      = 32;
    localparam int STAGES_MAX = 4;

    function automatic logic [W_MAX:0] exact_sum_f(
        input logic [W_MAX-1:0] a,
        input logic [W_MAX-1:0] b
    );
        exact_sum_f = {1'b0, a} + {1'b0, b};
    endfunction

    // Lower k bits are OR-ed; the upper part is an exact add seeded with a[k-1] & b[k-1].
    function automatic logic [W_MAX:0] approx_sum_f(
        input logic [W_MAX-1:0] a,
        input logic [W_MAX-1:0] b,
        input int               k
    );
        logic [W_MAX:0] mask;
        logic [W_MAX:0] lo;
        logic [W_MAX:0] hi;
        logic [4:0]     km1;
        logic           c;
        mask = '0;
        lo   = '0;
        hi   = '0;
        km1  = 5'd0;
        c    = 1'b0;
        if (k == 0) begin
            approx_sum_f = exact_sum_f(a, b);
        end else begin
            km1  = 5'(k - 1);
            mask = ({{W_MAX{1'b0}}, 1'b1} << k) - {{W_MAX{1'b0}}, 1'b1};
            lo   = {1'b0, a | b} & mask;
            c    = a[km1] & b[km1];
            hi   = (({1'b0, a} >> k) + ({1'b0, b} >> k) + {{W_MAX{1'b0}}, c}) << k;
            approx_sum_f = hi | lo;
        end
    endfunction

    function automatic logic [W_MAX:0] abs_diff_f(
        input logic [W_MAX:0] x,
        input logic [W_MAX:0] y
    );
        if (x >= y) begin
            abs_diff_f = x - y;
        end else begin
            abs_diff_f = y - x;
        end
    endfunction

endpackage

// File: rtl/approx_add_stage.sv
// One valid/ready register slice; it loads whenever it is empty or its
// content is being taken downstream, so bubbles collapse.
module approx_add_stage #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid_i,
    input  logic [DW-1:0] in_data_i,
    input  logic          out_ready_i,
    output logic          out_valid_o,
    output logic [DW-1:0] out_data_o
);

    logic          valid_q;
    logic          valid_d;
    logic [DW-1:0] data_q;
    logic [DW-1:0] data_d;
    logic          adv_s;

    assign adv_s = !valid_q || out_ready_i;

    // Next-state: load on advance, otherwise hold so the output stays stable.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (adv_s) begin
            valid_d = in_valid_i;
            if (in_valid_i) begin
                data_d = in_data_i;
            end else begin
                data_d = data_q;
            end
        end else begin
            valid_d = valid_q;
            data_d  = data_q;
        end
    end

    // Slice register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

endmodule

// File: rtl/approx_add_pipe.sv
// Pipelined lower-part-OR approximate adder with valid/ready streaming.
// Define ERR_MON_EN to add the error monitor (err_clr/err_cnt/err_max/err_sum).
module approx_add_pipe
    import approx_add_pkg::*;
#(
    parameter int W      = 8,
    parameter int K      = 4,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_approx,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W:0]   out_sum,
    output logic         out_approx
`ifdef ERR_MON_EN
    ,
    input  logic             err_clr,
    output logic [CNT_W-1:0] err_cnt,
    output logic [W:0]       err_max,
    output logic [CNT_W-1:0] err_sum
`endif
);

    localparam int WP1 = W + 1;
    localparam int P0W = 2 * W + 1;
`ifdef ERR_MON_EN
    localparam int PW  = 2 * WP1 + 1;
`else
    localparam int PW  = WP1 + 1;
`endif

    if (W < 2 || W > W_MAX || K < 0 || K >= W || STAGES < 1 || STAGES > STAGES_MAX || CNT_W < 1) begin : g_bad_cfg
        $error("approx_add_pipe: parameter out of range");
    end

    logic           vld_s      [STAGES];
    logic           down_rdy_s [STAGES];
    logic [PW-1:0]  pdata_s    [STAGES];
    logic [P0W-1:0] s0_data_s;
    logic [W-1:0]   s0_a_s;
    logic [W-1:0]   s0_b_s;
    logic           s0_approx_s;
    logic [W_MAX-1:0] a_ext_s;
    logic [W_MAX-1:0] b_ext_s;
    logic [W:0]     sum_apx_s;
    logic [W:0]     sum_exa_s;
    logic [W:0]     sum_s;
    logic [PW-1:0]  pay_s;
    logic [PW-1:0]  fin_s;

    // Stage n may advance when stage n+1 is empty or itself advancing; computed
    // from registered valids only, so in_valid never reaches in_ready.
    always_comb begin
        for (int n = 0; n < STAGES; n++) begin
            down_rdy_s[n] = out_ready;
        end
        for (int n = STAGES - 2; n >= 0; n--) begin
            down_rdy_s[n] = !vld_s[n+1] || down_rdy_s[n+1];
        end
    end

    assign in_ready = !vld_s[0] || down_rdy_s[0];

    approx_add_stage #(.DW(P0W)) u_stage0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_data_i   ({in_approx, in_b, in_a}),
        .out_ready_i (down_rdy_s[0]),
        .out_valid_o (vld_s[0]),
        .out_data_o  (s0_data_s)
    );

    assign {s0_approx_s, s0_b_s, s0_a_s} = s0_data_s;

    // Zero-extend operands to the helper width.
    always_comb begin
        a_ext_s = '0;
        b_ext_s = '0;
        a_ext_s[W-1:0] = s0_a_s;
        b_ext_s[W-1:0] = s0_b_s;
    end

    assign sum_apx_s = WP1'(approx_sum_f(a_ext_s, b_ext_s, K));
    assign sum_exa_s = WP1'(exact_sum_f(a_ext_s, b_ext_s));

    // Mode select; K=0 degenerates to the exact sum.
    always_comb begin
        sum_s = sum_exa_s;
        if (s0_approx_s && (K > 0)) begin
            sum_s = sum_apx_s;
        end else begin
            sum_s = sum_exa_s;
        end
    end

`ifdef ERR_MON_EN
    assign pay_s = {sum_exa_s, s0_approx_s, sum_s};
`else
    assign pay_s = {s0_approx_s, sum_s};
`endif

    assign pdata_s[0] = pay_s;

    for (genvar n = 1; n < STAGES; n++) begin : g_stage
        approx_add_stage #(.DW(PW)) u_stage (
            .clk         (clk),
            .rst_n       (rst_n),
            .in_valid_i  (vld_s[n-1]),
            .in_data_i   (pdata_s[n-1]),
            .out_ready_i (down_rdy_s[n]),
            .out_valid_o (vld_s[n]),
            .out_data_o  (pdata_s[n])
        );
    end

    assign fin_s      = pdata_s[STAGES-1];
    assign out_valid  = vld_s[STAGES-1];
    assign out_sum    = fin_s[W:0];
    assign out_approx = fin_s[W+1];

`ifdef ERR_MON_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W:0]       max_q, max_d;
    logic [CNT_W-1:0] esum_q, esum_d;
    logic [W:0]       exact_fin_s;
    logic [W_MAX:0]   obs_ext_s;
    logic [W_MAX:0]   ref_ext_s;
    logic [W:0]       diff_s;
    logic [63:0]      esum_ext_s;
    logic [63:0]      diff_ext_s;
    logic [63:0]      cmax_ext_s;
    logic [63:0]      acc_s;
    logic             hs_s;

    assign exact_fin_s = fin_s[2*W+2:W+2];
    assign hs_s        = out_valid && out_ready && out_approx;

    // Error magnitude and saturating accumulator candidate.
    always_comb begin
        obs_ext_s  = '0;
        ref_ext_s  = '0;
        esum_ext_s = '0;
        diff_ext_s = '0;
        cmax_ext_s = '0;
        obs_ext_s[W:0] = out_sum;
        ref_ext_s[W:0] = exact_fin_s;
        diff_s = WP1'(abs_diff_f(obs_ext_s, ref_ext_s));
        esum_ext_s[CNT_W-1:0] = esum_q;
        diff_ext_s[W:0]       = diff_s;
        cmax_ext_s[CNT_W-1:0] = '1;
        acc_s = esum_ext_s + diff_ext_s;
    end

    // Monitor next-state; clear takes priority over an accepted result.
    always_comb begin
        cnt_d  = cnt_q;
        max_d  = max_q;
        esum_d = esum_q;
        if (err_clr) begin
            cnt_d  = '0;
            max_d  = '0;
            esum_d = '0;
        end else if (hs_s) begin
            if ((diff_s != '0) && (cnt_q != '1)) begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_d = cnt_q;
            end
            if (diff_s > max_q) begin
                max_d = diff_s;
            end else begin
                max_d = max_q;
            end
            if (acc_s > cmax_ext_s) begin
                esum_d = '1;
            end else begin
                esum_d = acc_s[CNT_W-1:0];
            end
        end else begin
            cnt_d  = cnt_q;
            max_d  = max_q;
            esum_d = esum_q;
        end
    end

    // Monitor registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            max_q  <= '0;
            esum_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            max_q  <= max_d;
            esum_q <= esum_d;
        end
    end

    assign err_cnt = cnt_q;
    assign err_max = max_q;
    assign err_sum = esum_q;
`endif

endmodule

// File: tb/tb_approx_add_pipe.sv
// Directed bench: W=8/K=4/STAGES=2 instance plus a W=16/K=0/STAGES=4 instance.
module tb_approx_add_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, in_approx, out_valid, out_ready, out_approx;
    logic [7:0]  in_a, in_b;
    logic [8:0]  out_sum;
    logic        in_valid2, in_ready2, in_approx2, out_valid2, out_ready2, out_approx2;
    logic [15:0] in_a2, in_b2;
    logic [16:0] out_sum2;
    int          nvec = 0;
    int          nerr = 0;
`ifdef ERR_MON_EN
    logic        err_clr, err_clr2;
    logic [15:0] err_cnt, err_sum, err_cnt2, err_sum2;
    logic [8:0]  err_max;
    logic [16:0] err_max2;
`endif

    approx_add_pipe #(.W(8), .K(4), .STAGES(2), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_approx(in_approx), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_approx(out_approx)
`ifdef ERR_MON_EN
        , .err_clr(err_clr), .err_cnt(err_cnt), .err_max(err_max), .err_sum(err_sum)
`endif
    );

    approx_add_pipe #(.W(16), .K(0), .STAGES(4), .CNT_W(16)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_a(in_a2), .in_b(in_b2), .in_approx(in_approx2), .out_valid(out_valid2),
        .out_ready(out_ready2), .out_sum(out_sum2), .out_approx(out_approx2)
`ifdef ERR_MON_EN
        , .err_clr(err_clr2), .err_cnt(err_cnt2), .err_max(err_max2), .err_sum(err_sum2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        nvec++;
        assert (obs === exp_v) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Reference for W=8, K=4.
    function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b, input logic ap);
        logic [4:0] hi;
        logic [3:0] lo;
        if (!ap) return {1'b0, a} + {1'b0, b};
        lo = a[3:0] | b[3:0];
        hi = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'b0000, a[3] & b[3]};
        return {hi, lo};
    endfunction

    // Single transaction on the 2-stage DUT; entered and left at a negedge.
    task automatic send1(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic ap, input logic [8:0] exp_s);
        in_a = a; in_b = b; in_approx = ap; in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
        @(posedge clk); @(negedge clk);
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
        chk({tag, "_sum"}, 32'(out_sum), 32'(exp_s));
        chk({tag, "_mode"}, 32'(out_approx), 32'(ap));
        @(posedge clk); @(negedge clk);
    endtask

    // Single transaction on the 4-stage DUT.
    task automatic send2(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic ap, input logic [16:0] exp_s);
        in_a2 = a; in_b2 = b; in_approx2 = ap; in_valid2 = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid2 = 1'b0;
        for (int i = 1; i < 4; i++) begin
            chk({tag, "_early"}, 32'(out_valid2), 32'd0);
            @(posedge clk); @(negedge clk);
        end
        chk({tag, "_vld"}, 32'(out_valid2), 32'd1);
        chk({tag, "_sum"}, 32'(out_sum2), 32'(exp_s));
        @(posedge clk); @(negedge clk);
    endtask

    logic [7:0] ba [4];
    logic [7:0] bb [4];
    logic       bm [4];
    logic [9:0] exp_q [$];
    logic [9:0] exp_e;
    int         issued, got, cyc;
    logic       held, acc;
    logic [8:0] held_sum;
    logic       held_mode;

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00; in_approx = 1'b0; out_ready = 1'b1;
        in_valid2 = 1'b0; in_a2 = 16'h0000; in_b2 = 16'h0000; in_approx2 = 1'b0; out_ready2 = 1'b1;
`ifdef ERR_MON_EN
        err_clr = 1'b0; err_clr2 = 1'b0;
`endif
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum", 32'(out_sum), 32'd0);
        chk("rst_out_approx", 32'(out_approx), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid2", 32'(out_valid2), 32'd0);
        chk("rst_in_ready2", 32'(in_ready2), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        send1("ap_0f01", 8'h0F, 8'h01, 1'b1, 9'h00F);
`ifdef ERR_MON_EN
        chk("err_cnt_1", 32'(err_cnt), 32'd1);
        chk("err_max_1", 32'(err_max), 32'd1);
`endif
        send1("ex_0f01", 8'h0F, 8'h01, 1'b0, 9'h010);
`ifdef ERR_MON_EN
        chk("err_cnt_ex", 32'(err_cnt), 32'd1);
`endif
        send1("ap_ffff", 8'hFF, 8'hFF, 1'b1, 9'h1FF);
        send1("ex_ffff", 8'hFF, 8'hFF, 1'b0, 9'h1FE);
        send1("ap_3828", 8'h38, 8'h28, 1'b1, 9'h068);
        send1("ex_3828", 8'h38, 8'h28, 1'b0, 9'h060);
`ifdef ERR_MON_EN
        chk("err_cnt_3", 32'(err_cnt), 32'd3);
        chk("err_max_8", 32'(err_max), 32'd8);
        chk("err_sum_10", 32'(err_sum), 32'd10);
        err_clr = 1'b1;
        @(posedge clk); @(negedge clk);
        err_clr = 1'b0;
        chk("err_clr_cnt", 32'(err_cnt), 32'd0);
        chk("err_clr_max", 32'(err_max), 32'd0);
        chk("err_clr_sum", 32'(err_sum), 32'd0);
`endif

        // Back-to-back burst with out_ready high: one result per cycle.
        ba[0] = 8'h12; bb[0] = 8'h34; bm[0] = 1'b1;
        ba[1] = 8'h9C; bb[1] = 8'h6B; bm[1] = 1'b0;
        ba[2] = 8'hF0; bb[2] = 8'h1F; bm[2] = 1'b1;
        ba[3] = 8'h7F; bb[3] = 8'h88; bm[3] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c < 4) begin
                in_a = ba[c]; in_b = bb[c]; in_approx = bm[c]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c < 4) chk("burst_in_ready", 32'(in_ready), 32'd1);
            @(posedge clk); @(negedge clk);
            if (c >= 1 && c <= 4) begin
                chk("burst_vld", 32'(out_valid), 32'd1);
                chk("burst_sum", 32'(out_sum), 32'(model(ba[c-1], bb[c-1], bm[c-1])));
            end else begin
                chk("burst_idle", 32'(out_valid), 32'd0);
            end
        end

        // 16 random transactions with random back-pressure.
        issued = 0; got = 0; cyc = 0; held = 1'b0; acc = 1'b0;
        held_sum = 9'h000; held_mode = 1'b0;
        while (got < 16 && cyc < 400) begin
            if (held) begin
                chk("stall_vld", 32'(out_valid), 32'd1);
                chk("stall_sum", 32'(out_sum), 32'(held_sum));
                chk("stall_mode", 32'(out_approx), 32'(held_mode));
            end
            if (acc || !in_valid) begin
                if (issued < 16) begin
                    in_a = 8'($urandom); in_b = 8'($urandom);
                    in_approx = 1'($urandom_range(0, 1)); in_valid = 1'b1;
                    issued++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (out_valid && out_ready) begin
                chk("stream_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    exp_e = exp_q.pop_front();
                    chk("stream_sum", 32'(out_sum), 32'(exp_e[8:0]));
                    chk("stream_mode", 32'(out_approx), 32'(exp_e[9]));
                end
                got++;
            end
            held = out_valid && !out_ready;
            held_sum = out_sum;
            held_mode = out_approx;
            acc = in_valid && in_ready;
            if (acc) exp_q.push_back({in_approx, model(in_a, in_b, in_approx)});
            @(posedge clk); @(negedge clk);
            cyc++;
        end
        chk("stream_count", 32'(got), 32'd16);
        chk("stream_leftover", 32'(exp_q.size()), 32'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);

        // Reset with two transactions in flight.
        in_a = 8'h21; in_b = 8'h13; in_approx = 1'b0; in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        in_a = 8'h44; in_b = 8'h55;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        chk("pre_rst_vld", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", 32'(out_valid), 32'd0);
        chk("mid_rst_sum", 32'(out_sum), 32'd0);
        chk("mid_rst_rdy", 32'(in_ready), 32'd1);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            chk("no_stale", 32'(out_valid), 32'd0);
        end
        send1("post_rst", 8'h21, 8'h13, 1'b1, 9'h033);

        // W=16, K=0, STAGES=4: both modes exact.
        send2("k0_ap", 16'hFFFF, 16'h0001, 1'b1, 17'h10000);
        send2("k0_ex", 16'hFFFF, 16'h0001, 1'b0, 17'h10000);
        send2("k0_ffff", 16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFE);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
